seg_scan_decoder: RTL
=====================

// Module: seg_scan_decoder
// PURPOSE
//  Reads a multiplexed, active-low 7-segment display bus (segments + anode enables) and recovers the
//  BCD digit shown in every position: per-slot digit, blank and valid flags, plus error pulses.
//  Sits beside the display driver as a self-check/loopback monitor; pure observer, never drives the bus.
// PARAMETERS
//  NUM_DIGITS     4   number of anode positions / digit slots (1..8)
//  STABLE_CYCLES  4   consecutive identical samples needed before a slot is captured (2..255)
// PORTS
//  clk          in   1             system clock; all logic on posedge
//  reset        in   1             synchronous, active-high reset
//  segments     in   7             observed segments {g,f,e,d,c,b,a}, active-low
//  anodes       in   NUM_DIGITS    observed anode enables, active-low, one low at a time expected
//  digits       out  4*NUM_DIGITS  recovered BCD, slot i at [4i+3:4i]
//  digit_valid  out  NUM_DIGITS    slot i holds a legal 0-9 capture
//  digit_blank  out  NUM_DIGITS    slot i last captured as all-off (7'b1111111)
//  update       out  1             1-cycle pulse: a slot was captured this cycle
//  update_idx   out  3             slot index for update; 0 when update=0
//  pattern_err  out  1             1-cycle pulse: captured pattern was neither 0-9 nor blank
//  scan_err     out  1             1-cycle pulse: more than one anode low in the current sample
// BEHAVIOUR
//  - Reset: all outputs 0, sample registers = all-ones, stable counter 0, captured flag 0.
//  - Legal patterns: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//    7=1111000 8=0000000 9=0010000; blank=1111111; anything else is illegal.
//  - Sampling: each cycle {anodes,segments} registers into s_q. The same edge updates cnt:
//    input == s_q and exactly one anode low -> cnt = min(cnt+1, STABLE_CYCLES);
//    input != s_q with exactly one anode low -> cnt = 1, captured cleared;
//    no anode low, or more than one low -> cnt = 0, captured cleared.
//  - Capture: on the edge where cnt becomes STABLE_CYCLES and captured=0, slot i (the low anode)
//    updates: legal digit -> digits[i]=value, valid[i]=1, blank[i]=0; blank -> valid[i]=0,
//    blank[i]=1, digits[i] unchanged; illegal -> valid[i]=0, blank[i]=0, digits[i] unchanged,
//    pattern_err=1. update=1 and update_idx=i on that same edge in all three cases. Then captured=1.
//  - Latency: value present at input before edge 1 and held -> outputs change at edge STABLE_CYCLES.
//  - One capture per dwell; a held value never re-pulses update. A glitch restarts the count, so a
//    dwell shorter than STABLE_CYCLES cycles is ignored and slot i keeps its prior contents.
//  - scan_err is registered: asserts the cycle after a multi-low anode input, once per input cycle.
//  - Captured slots persist until overwritten or reset; no timeout. Reset mid-dwell discards progress.
//  - anode bits at index >= NUM_DIGITS do not exist; update_idx upper bits are 0 when NUM_DIGITS<8.
// STRUCTURE
//  - seg_pkg: SEG_0..SEG_9, SEG_BLANK 7-bit active-low constants; seg_class_t enum {DIG, BLANK, ILLEGAL}.
//  - Sub-module seg7_decode: combinational segments -> {class, 4-bit value}; the inverse of the
//    team's digit-to-segment encoder, built from the same seg_pkg constants.
//  - Top: sample register, stable counter, one-hot-cold anode check + index encoder, slot register files.
// TESTING
//  - Reset: reset=1 for 3 cycles with any inputs -> all outputs 0, no pulses for the 3 cycles after.
//  - Capture: anodes=1110, segments=0110000 held 6 cycles -> update=1, update_idx=0 at edge 4 only;
//    digits[3:0]=3, digit_valid=0001.
//  - Full scan: rotate anodes 1110/1101/1011/0111 with 1,2,7,9, 8 cycles each -> digits=16'h9721,
//    digit_valid=1111, exactly 4 update pulses per rotation.
//  - Short dwell: slot 1 already 2; drive 0010010 on anodes=1101 for 3 cycles, then anodes=1111
//    -> no update; digits[7:4] stays 2.
//  - Blank/illegal: slot 2 holds 5; 1111111 on anodes=1011 for 5 cycles -> blank[2]=1, valid[2]=0,
//    digits[11:8]=5; then 0101010 -> pattern_err one pulse, blank[2]=0.
//  - Scan error: anodes=1100 for 2 cycles -> scan_err high 2 cycles, no update; reset asserted at
//    cnt=3 of a later dwell -> no capture, all outputs 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared segment constants and decode types for the 7-segment scan monitor.
// Patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    CLS_DIG,
    CLS_BLANK,
    CLS_ILLEGAL
  } seg_class_t;

  typedef struct packed {
    seg_class_t cls;
    logic [3:0] value;
  } seg_decoded_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern classifier: the inverse of the digit-to-segment encoder.
// Any pattern that is not a digit or all-off is reported as illegal with value 0.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [6:0]   segments,
  output seg_decoded_t decoded
);

  always_comb begin
    decoded = '{cls: CLS_ILLEGAL, value: 4'd0};
    case (segments)
      SEG_0:     decoded = '{cls: CLS_DIG, value: 4'd0};
      SEG_1:     decoded = '{cls: CLS_DIG, value: 4'd1};
      SEG_2:     decoded = '{cls: CLS_DIG, value: 4'd2};
      SEG_3:     decoded = '{cls: CLS_DIG, value: 4'd3};
      SEG_4:     decoded = '{cls: CLS_DIG, value: 4'd4};
      SEG_5:     decoded = '{cls: CLS_DIG, value: 4'd5};
      SEG_6:     decoded = '{cls: CLS_DIG, value: 4'd6};
      SEG_7:     decoded = '{cls: CLS_DIG, value: 4'd7};
      SEG_8:     decoded = '{cls: CLS_DIG, value: 4'd8};
      SEG_9:     decoded = '{cls: CLS_DIG, value: 4'd9};
      SEG_BLANK: decoded = '{cls: CLS_BLANK, value: 4'd0};
      default:   decoded = '{cls: CLS_ILLEGAL, value: 4'd0};
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive monitor for a multiplexed active-low 7-segment bus: waits for a stable dwell on
// exactly one anode, then captures the decoded digit into that anode's slot.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segments,
  input  logic [NUM_DIGITS-1:0]   anodes,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    update,
  output logic [2:0]              update_idx,
  output logic                    pattern_err,
  output logic                    scan_err
);

  localparam int         SW         = NUM_DIGITS + 7;
  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  logic [SW-1:0] sample_reg;
  logic [7:0]    cnt_reg, cnt_next;
  logic          captured_reg, captured_next;
  logic [3:0]    low_count;
  logic [2:0]    low_idx;
  logic          one_low, multi_low, same, capture;
  seg_decoded_t  decoded;

  seg7_decode u_decode (
    .segments (segments),
    .decoded  (decoded)
  );

  // One-hot-cold check and index encoder over the active-low anode bus.
  always_comb begin
    low_count = 4'd0;
    low_idx   = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!anodes[i]) begin
        low_count = low_count + 4'd1;
        low_idx   = 3'(i);
      end
    end
  end

  assign one_low   = (low_count == 4'd1);
  assign multi_low = (low_count > 4'd1);
  assign same      = ({anodes, segments} == sample_reg);

  // The captured flag gates the capture so a held value fires exactly once per dwell.
  always_comb begin
    cnt_next      = 8'd0;
    captured_next = 1'b0;
    capture       = 1'b0;
    if (one_low) begin
      if (same) begin
        cnt_next      = (cnt_reg >= STABLE_LIM) ? STABLE_LIM : cnt_reg + 8'd1;
        captured_next = captured_reg;
        capture       = (cnt_next == STABLE_LIM) && !captured_reg;
      end else begin
        cnt_next = 8'd1;
      end
    end
    if (capture) captured_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_reg   <= '1;
      cnt_reg      <= 8'd0;
      captured_reg <= 1'b0;
      update       <= 1'b0;
      update_idx   <= 3'd0;
      pattern_err  <= 1'b0;
      scan_err     <= 1'b0;
    end else begin
      sample_reg   <= {anodes, segments};
      cnt_reg      <= cnt_next;
      captured_reg <= captured_next;
      update       <= capture;
      update_idx   <= capture ? low_idx : 3'd0;
      pattern_err  <= capture && (decoded.cls == CLS_ILLEGAL);
      scan_err     <= multi_low;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
    logic [3:0] digit_reg;
    logic       valid_reg;
    logic       blank_reg;
    logic       hit;

    assign hit = capture && (low_idx == 3'(gi));

    // Blank and illegal captures keep the previous digit value but drop validity.
    always_ff @(posedge clk) begin
      if (reset) begin
        digit_reg <= 4'd0;
        valid_reg <= 1'b0;
        blank_reg <= 1'b0;
      end else if (hit) begin
        case (decoded.cls)
          CLS_DIG: begin
            digit_reg <= decoded.value;
            valid_reg <= 1'b1;
            blank_reg <= 1'b0;
          end
          CLS_BLANK: begin
            valid_reg <= 1'b0;
            blank_reg <= 1'b1;
          end
          default: begin
            valid_reg <= 1'b0;
            blank_reg <= 1'b0;
          end
        endcase
      end
    end

    assign digits[4*gi +: 4] = digit_reg;
    assign digit_valid[gi]   = valid_reg;
    assign digit_blank[gi]   = blank_reg;
  end

endmodule
